int_to_single: RTL and testbench

INT_TO_SINGLE -- requirements
Module: int_to_single

---
 rtl/int_to_single_if.sv | 28 ++
 rtl/int_to_single.sv | 72 +++++++
 tb/tb_int_to_single.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/int_to_single_if.sv
// rtl/int_to_single_if.sv - operand and result handshake bundle for int_to_single
interface int_to_single_if;
    logic [31:0] int_to_single_a;
    logic        int_to_single_a_stb;
    logic        int_to_single_a_ack;
    logic [31:0] int_to_single_z;
    logic        int_to_single_z_stb;
    logic        int_to_single_z_ack;

    // slave: the converter; master: the producer/consumer around it
    modport slave (
        input  int_to_single_a,
        input  int_to_single_a_stb,
        output int_to_single_a_ack,
        output int_to_single_z,
        output int_to_single_z_stb,
        input  int_to_single_z_ack
    );

    modport master (
        output int_to_single_a,
        output int_to_single_a_stb,
        input  int_to_single_a_ack,
        input  int_to_single_z,
        input  int_to_single_z_stb,
        output int_to_single_z_ack
    );
endinterface

// File: rtl/int_to_single.sv
// rtl/int_to_single.sv - 3-stage int32 to IEEE-754 single converter with
// stall-all backpressure and round-to-nearest-even
module int_to_single (
    input  logic            clk,
    input  logic            rst,
    int_to_single_if.slave  bus
);
    logic        adv;

    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;

    logic        s2_valid;
    logic        s2_sign;
    logic        s2_zero;
    logic [4:0]  s2_lz;
    logic [31:0] s2_norm;

    logic        s3_valid;
    logic [31:0] s3_z;

    logic [4:0]  lz_c;
    logic [7:0]  exp_c;
    logic [23:0] mant_c;
    logic        round_c;
    logic [31:0] z_c;

    assign adv                     = !s3_valid | bus.int_to_single_z_ack;
    assign bus.int_to_single_a_ack = adv & !rst;
    assign bus.int_to_single_z     = s3_z;
    assign bus.int_to_single_z_stb = s3_valid;

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz_c = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (s1_mag[i]) lz_c = 5'(31 - i);
        end
    end

    always_comb begin
        exp_c   = 8'd158 - {3'b000, s2_lz};
        round_c = s2_norm[7] & ((|s2_norm[6:0]) | s2_norm[8]);
        mant_c  = {1'b0, s2_norm[30:8]} + {23'd0, round_c};
        // Carry-out leaves mant_c[22:0] all zero; only the exponent moves.
        if (mant_c[23]) exp_c = exp_c + 8'd1;
        z_c = s2_zero ? 32'h0000_0000 : {s2_sign, exp_c, mant_c[22:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_z     <= 32'h0000_0000;
        end else if (adv) begin
            s1_valid <= bus.int_to_single_a_stb;
            s1_sign  <= bus.int_to_single_a[31];
            s1_mag   <= bus.int_to_single_a[31] ? (~bus.int_to_single_a + 32'd1)
                                                : bus.int_to_single_a;
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= (s1_mag == 32'd0);
            s2_lz    <= lz_c;
            s2_norm  <= s1_mag << lz_c;
            s3_valid <= s2_valid;
            // z keeps its last value across bubbles.
            if (s2_valid) s3_z <= z_c;
        end
    end
endmodule

// File: tb/tb_int_to_single.sv
// tb/tb_int_to_single.sv - directed-vector and scoreboard bench for int_to_single
module tb_int_to_single;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int_to_single_if bus();

    int_to_single dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: locate the top bit, shift to 24 bits, then round by
    // comparing the discarded remainder against exactly one half ulp.
    function automatic logic [31:0] ref_conv(input logic [31:0] a);
        logic [63:0] m, q, rem, half;
        logic [31:0] e;
        int          p, sh;
        if (a == 32'd0) return 32'd0;
        m = a[31] ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        p = 63;
        while (!m[p]) p--;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end
        if (q[24]) begin
            q = q >> 1;
            p = p + 1;
        end
        e = 32'(127 + p);
        return {a[31], e[7:0], q[22:0]};
    endfunction

    // One cycle of handshake: drive at negedge, settle, then account for
    // both transfers that the coming posedge will perform.
    task automatic step(input logic stb, input logic [31:0] av, input logic ack, output logic took);
        @(negedge clk);
        bus.int_to_single_a     = av;
        bus.int_to_single_a_stb = stb;
        bus.int_to_single_z_ack = ack;
        #1;
        took = stb && bus.int_to_single_a_ack;
        if (bus.int_to_single_z_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected no result", bus.int_to_single_z);
            end else begin
                check("stream_z", bus.int_to_single_z, exp_q[0]);
                if (ack) void'(exp_q.pop_front());
            end
        end
        if (took) exp_q.push_back(ref_conv(av));
    endtask

    task automatic apply_vec(input vec_t v);
        int lat;
        @(negedge clk);
        bus.int_to_single_a     = v.a;
        bus.int_to_single_a_stb = 1'b1;
        bus.int_to_single_z_ack = 1'b1;
        #1;
        check({v.name, "_a_ack"}, {31'd0, bus.int_to_single_a_ack}, 32'd1);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.int_to_single_a_stb = 1'b0;
            #1;
            if (bus.int_to_single_z_stb) begin
                lat = c;
                break;
            end
        end
        check({v.name, "_latency"}, 32'(lat), 32'd3);
        check(v.name, bus.int_to_single_z, v.z);
    endtask

    initial begin
        logic        took;
        int          accepts;
        logic [31:0] sv [3];
        logic [31:0] av;

        vecs.push_back('{32'h0000_0000, 32'h0000_0000, "zero"});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, "one"});
        vecs.push_back('{32'hFFFF_FFFF, 32'hBF80_0000, "minus_one"});
        vecs.push_back('{32'h7FFF_FFFF, 32'h4F00_0000, "max_pos"});
        vecs.push_back('{32'h8000_0000, 32'hCF00_0000, "min_neg"});
        vecs.push_back('{32'h0100_0001, 32'h4B80_0000, "tie_even_down"});
        vecs.push_back('{32'h0100_0003, 32'h4B80_0002, "tie_up"});
        vecs.push_back('{32'h0100_0002, 32'h4B80_0001, "exact"});
        vecs.push_back('{32'hFEFF_FFFF, 32'hCB80_0000, "neg_carry"});

        bus.int_to_single_a     = 32'd0;
        bus.int_to_single_a_stb = 1'b1;
        bus.int_to_single_z_ack = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_z_stb", {31'd0, bus.int_to_single_z_stb}, 32'd0);
        check("reset_z", bus.int_to_single_z, 32'd0);
        check("reset_a_ack", {31'd0, bus.int_to_single_a_ack}, 32'd0);
        rst = 1'b0;
        bus.int_to_single_a_stb = 1'b0;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Back-to-back stream, results on consecutive cycles.
        sv[0] = 32'h3F80_0000;
        sv[1] = 32'h4000_0000;
        sv[2] = 32'h4040_0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.int_to_single_a     = 32'(c + 1);
            bus.int_to_single_a_stb = (c < 3);
            bus.int_to_single_z_ack = 1'b1;
            #1;
            if (c >= 3) begin
                check($sformatf("stream_stb%0d", c), {31'd0, bus.int_to_single_z_stb}, 32'd1);
                check($sformatf("stream_z%0d", c), bus.int_to_single_z, sv[c - 3]);
            end else begin
                check($sformatf("stream_idle%0d", c), {31'd0, bus.int_to_single_z_stb}, 32'd0);
            end
        end
        bus.int_to_single_a_stb = 1'b0;
        repeat (2) @(posedge clk);

        // Backpressure: only three operands fit before the pipe stalls.
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 32'(10 + accepts), 1'b0, took);
            if (took) accepts++;
        end
        check("bp_accepts", 32'(accepts), 32'd3);
        for (int c = 0; c < 12 && accepts < 5; c++) begin
            step(1'b1, 32'(10 + accepts), 1'b1, took);
            if (took) accepts++;
        end
        for (int c = 0; c < 8; c++) step(1'b0, 32'd0, 1'b1, took);
        check("bp_accepts_total", 32'(accepts), 32'd5);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-flight discards both in-flight operands.
        step(1'b1, 32'd77, 1'b1, took);
        step(1'b1, 32'd78, 1'b1, took);
        @(negedge clk);
        rst = 1'b1;
        bus.int_to_single_a_stb = 1'b1;
        #1;
        check("rst_a_ack", {31'd0, bus.int_to_single_a_ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.int_to_single_a_stb = 1'b0;
        #1;
        check("rst_z_stb", {31'd0, bus.int_to_single_z_stb}, 32'd0);
        check("rst_z", bus.int_to_single_z, 32'd0);
        exp_q.delete();
        for (int c = 0; c < 6; c++) step(1'b0, 32'd0, 1'b1, took);
        apply_vec('{32'h0000_0005, 32'h40A0_0000, "after_reset"});

        // Random stream with random backpressure.
        for (int c = 0; c < 4000; c++) begin
            case ($urandom_range(0, 7))
                0:       av = 32'h8000_0000;
                1:       av = 32'(int'($urandom_range(0, 4)) - 2);
                2:       av = $urandom >> $urandom_range(0, 31);
                default: av = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, av, $urandom_range(0, 3) != 0, took);
        end
        for (int c = 0; c < 8; c++) step(1'b0, 32'd0, 1'b1, took);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
